// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
package mips_pkg;
   typedef enum logic {S_RUN = 1'b0, S_MD = 1'b1} hc_state_t;
   localparam int unsigned REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stall/flush and mult/div controls out.
interface hazard_ctrl_if;
   import mips_pkg::*;
   logic [REG_W-1:0] rs_ID;
   logic [REG_W-1:0] rt_ID;
   logic             uses_rt_ID;
   logic             memtoreg_EX;
   logic             regwrite_EX;
   logic [REG_W-1:0] writereg_EX;
   logic             branch_taken_ID;
   logic             jump_ID;
   logic             md_start_ID;
   logic             md_is_div_ID;
   logic             mfhilo_ID;
   logic             imem_ready;
   logic             dmem_req_MEM;
   logic             dmem_ready;
   logic             stall_pc;
   logic             stall_if_id;
   logic             flush_if_id;
   logic             stall_id_ex;
   logic             flush_id_ex;
   logic             stall_ex_mem;
   logic             stall_mem_wb;
   logic             md_go;
   logic             md_busy;
   logic             md_done;

   modport master (
      output rs_ID, rt_ID, uses_rt_ID, memtoreg_EX, regwrite_EX, writereg_EX,
             branch_taken_ID, jump_ID, md_start_ID, md_is_div_ID, mfhilo_ID,
             imem_ready, dmem_req_MEM, dmem_ready,
      input  stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
             stall_ex_mem, stall_mem_wb, md_go, md_busy, md_done
   );

   modport slave (
      input  rs_ID, rt_ID, uses_rt_ID, memtoreg_EX, regwrite_EX, writereg_EX,
             branch_taken_ID, jump_ID, md_start_ID, md_is_div_ID, mfhilo_ID,
             imem_ready, dmem_req_MEM, dmem_ready,
      output stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
             stall_ex_mem, stall_mem_wb, md_go, md_busy, md_done
   );
endinterface

// File: rtl/md_timer.sv
// Mult/div occupancy timer: counts down the unit latency and flags busy/done.
module md_timer
   import mips_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned DIV_CYCLES  = 32,
   parameter int unsigned CNT_W       = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic go,
   input  logic is_div,
   output logic md_busy,
   output logic md_done
);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   hc_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A launch in the done cycle takes precedence and reloads the count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (go) begin
         state_d = S_MD;
         cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
      end else if (state_q == S_MD) begin
         if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
         else             state_d = S_RUN;
      end
   end

   always_comb begin
      md_busy = (state_q == S_MD) && (cnt_q != '0);
      md_done = (state_q == S_MD) && (cnt_q == '0);
   end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush priority logic with mult/div sequencing.
module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned DIV_CYCLES  = 32,
   parameter int unsigned CNT_W       = 6
) (
   input logic          clk,
   input logic          reset,
   hazard_ctrl_if.slave hif
);
   logic freeze, lu, mdh, hazard, redirect, imem_wait, go;
   logic busy_raw, done_raw;

   md_timer #(
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_md_timer (
      .clk    (clk),
      .reset  (reset),
      .go     (go),
      .is_div (hif.md_is_div_ID),
      .md_busy(busy_raw),
      .md_done(done_raw)
   );

   always_comb begin
      freeze = hif.dmem_req_MEM && !hif.dmem_ready;
      lu = hif.memtoreg_EX && hif.regwrite_EX && (hif.writereg_EX != REG_ZERO) &&
           ((hif.writereg_EX == hif.rs_ID) ||
            (hif.uses_rt_ID && (hif.writereg_EX == hif.rt_ID)));
      mdh       = busy_raw && (hif.md_start_ID || hif.mfhilo_ID);
      hazard    = !freeze && (lu || mdh);
      redirect  = !freeze && !lu && !mdh && (hif.branch_taken_ID || hif.jump_ID);
      imem_wait = !freeze && !hif.imem_ready;
      go        = hif.md_start_ID && !freeze && !lu && !mdh;
   end

   // Reset forces every output low, including the combinational controls.
   always_comb begin
      hif.stall_pc     = 1'b0;
      hif.stall_if_id  = 1'b0;
      hif.flush_if_id  = 1'b0;
      hif.stall_id_ex  = 1'b0;
      hif.flush_id_ex  = 1'b0;
      hif.stall_ex_mem = 1'b0;
      hif.stall_mem_wb = 1'b0;
      hif.md_go        = 1'b0;
      hif.md_busy      = 1'b0;
      hif.md_done      = 1'b0;
      if (!reset) begin
         hif.stall_pc     = freeze || hazard || imem_wait;
         hif.stall_if_id  = freeze || hazard;
         hif.flush_if_id  = redirect || (imem_wait && !hazard);
         hif.stall_id_ex  = freeze;
         hif.flush_id_ex  = hazard;
         hif.stall_ex_mem = freeze;
         hif.stall_mem_wb = freeze;
         hif.md_go        = go;
         hif.md_busy      = busy_raw;
         hif.md_done      = done_raw;
      end
   end
endmodule
